// File: rtl/code_entry.sv
// Secret-code entry for a codemaker: collects NUM_DIGITS legal digits on
// rising edges of the selected enter button, presents the code until acknowledged.
module code_entry #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 3,
    parameter int MAX_DIGIT  = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            take_code,
    input  logic                            active_p,
    input  logic                            enterA,
    input  logic                            enterB,
    input  logic [DIGIT_W-1:0]              digit_in,
    input  logic                            code_ack,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   code_out,
    output logic                            code_valid,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            err,
    output logic                            locked
);

    localparam int                 IDX_W    = $clog2(NUM_DIGITS);
    localparam int                 CODE_W   = NUM_DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_DIGIT);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DONE} state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               locked_q, locked_d;
    logic               enter_a_q, enter_a_d;
    logic               enter_b_q, enter_b_d;

    logic               sel_enter;
    logic               sel_prev;
    logic               press;

    // Both buttons are tracked continuously, so switching the source compares
    // the new button against its own last level and never fabricates a press.
    assign sel_enter = active_p ? enterB : enterA;
    assign sel_prev  = active_p ? enter_b_q : enter_a_q;
    assign press     = sel_enter & ~sel_prev;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        locked_d  = locked_q;
        enter_a_d = enterA;
        enter_b_d = enterB;

        case (state_q)
            IDLE: begin
                if (take_code) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                end
            end
            COLLECT: begin
                if (!take_code) begin
                    state_d = IDLE;
                    code_d  = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end else if (press) begin
                    if (digit_in > MAX_D) begin
                        err_d = 1'b1;
                    end else begin
                        for (int k = 0; k < NUM_DIGITS; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                code_d[k*DIGIT_W +: DIGIT_W] = digit_in;
                            end
                        end
                        if (idx_q == LAST_IDX) begin
                            state_d = HOLD;
                            idx_d   = '0;
                            valid_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (!take_code) begin
                    state_d = IDLE;
                    code_d  = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end else if (code_ack) begin
                    state_d  = DONE;
                    valid_d  = 1'b0;
                    locked_d = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            code_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            enter_a_q <= 1'b0;
            enter_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            enter_a_q <= enter_a_d;
            enter_b_q <= enter_b_d;
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign digit_idx  = idx_q;
    assign err        = err_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_code_entry.sv
// Directed table-driven bench for code_entry plus hand sequences for
// held buttons, take_code withdrawal and asynchronous reset.
module tb_code_entry;

    logic        clk;
    logic        reset;
    logic        take_code;
    logic        active_p;
    logic        enterA;
    logic        enterB;
    logic [2:0]  digit_in;
    logic        code_ack;
    logic [11:0] code_out;
    logic        code_valid;
    logic [1:0]  digit_idx;
    logic        err;
    logic        locked;

    int checks = 0;
    int errors = 0;

    code_entry #(.NUM_DIGITS(4), .DIGIT_W(3), .MAX_DIGIT(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .take_code  (take_code),
        .active_p   (active_p),
        .enterA     (enterA),
        .enterB     (enterB),
        .digit_in   (digit_in),
        .code_ack   (code_ack),
        .code_out   (code_out),
        .code_valid (code_valid),
        .digit_idx  (digit_idx),
        .err        (err),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tc;
        logic        ap;
        logic        ea;
        logic        eb;
        logic [2:0]  d;
        logic        ack;
        logic [11:0] code;
        logic        vld;
        logic [1:0]  idx;
        logic        e;
        logic        lk;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input int tc, input int ap, input int ea, input int eb,
                                input int d, input int ack, input int code, input int vld,
                                input int idx, input int e, input int lk);
        vec_t r;
        r.tc   = 1'(tc);
        r.ap   = 1'(ap);
        r.ea   = 1'(ea);
        r.eb   = 1'(eb);
        r.d    = 3'(d);
        r.ack  = 1'(ack);
        r.code = 12'(code);
        r.vld  = 1'(vld);
        r.idx  = 2'(idx);
        r.e    = 1'(e);
        r.lk   = 1'(lk);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int code, input int vld, input int idx,
                           input int e, input int lk);
        chk({tag, " code_out"},   32'(code_out),   32'(code));
        chk({tag, " code_valid"}, 32'(code_valid), 32'(vld));
        chk({tag, " digit_idx"},  32'(digit_idx),  32'(idx));
        chk({tag, " err"},        32'(err),        32'(e));
        chk({tag, " locked"},     32'(locked),     32'(lk));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic drive(input int tc, input int ap, input int ea, input int eb,
                         input int d, input int ack);
        @(negedge clk);
        take_code = 1'(tc);
        active_p  = 1'(ap);
        enterA    = 1'(ea);
        enterB    = 1'(eb);
        digit_in  = 3'(d);
        code_ack  = 1'(ack);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              tc ap ea eb d ack  code   v idx e lk
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 'h000, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 3, 0, 'h003, 0, 1, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 3, 0, 'h003, 0, 1, 0, 0);
        tbl[3]  = mk(1, 0, 1, 0, 7, 0, 'h003, 0, 1, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 7, 0, 'h003, 0, 1, 0, 0);
        tbl[5]  = mk(1, 0, 1, 0, 1, 0, 'h00B, 0, 2, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 1, 0, 'h00B, 0, 2, 0, 0);
        tbl[7]  = mk(1, 1, 1, 0, 2, 0, 'h00B, 0, 2, 0, 0);
        tbl[8]  = mk(1, 1, 1, 1, 5, 0, 'h14B, 0, 3, 0, 0);
        tbl[9]  = mk(1, 0, 1, 1, 4, 0, 'h14B, 0, 3, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 4, 0, 'h14B, 0, 3, 0, 0);
        // digits 3,1,5,0 in slots 0..3 -> 000_101_001_011
        tbl[11] = mk(1, 0, 1, 0, 0, 0, 'h14B, 1, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 'h14B, 1, 0, 0, 0);
        tbl[13] = mk(1, 0, 1, 0, 7, 0, 'h14B, 1, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 0, 0, 1, 'h14B, 0, 0, 0, 1);
        tbl[15] = mk(0, 0, 1, 0, 3, 0, 'h14B, 0, 0, 0, 1);
        tbl[16] = mk(1, 1, 0, 1, 2, 1, 'h14B, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 'h14B, 0, 0, 0, 1);

        reset = 1'b1; take_code = 1'b0; active_p = 1'b0; enterA = 1'b0;
        enterB = 1'b0; digit_in = 3'd0; code_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].tc, tbl[i].ap, tbl[i].ea, tbl[i].eb, tbl[i].d, tbl[i].ack);
            chk_all($sformatf("vec%0d", i), tbl[i].code, tbl[i].vld, tbl[i].idx,
                    tbl[i].e, tbl[i].lk);
        end

        // Asynchronous reset while locked, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk_all("async_done", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        drive(1, 1, 0, 0, 0, 0);
        chk_all("enter_collect", 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 1, (i == 0) ? 2 : 4, 0);
            chk_all($sformatf("held%0d", i), 'h002, 0, 1, 0, 0);
        end
        drive(1, 1, 0, 0, 4, 0);
        drive(1, 1, 0, 1, 7, 0);
        chk_all("illegal7", 'h002, 0, 1, 1, 0);
        drive(1, 1, 0, 0, 7, 0);
        chk_all("err_clear", 'h002, 0, 1, 0, 0);
        drive(1, 1, 0, 1, 4, 0);
        chk_all("store4", 'h022, 0, 2, 0, 0);
        drive(1, 1, 0, 0, 4, 0);

        // Withdrawal of take_code wins over a simultaneous press.
        drive(0, 1, 0, 1, 1, 0);
        chk_all("withdraw", 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        chk_all("reenter", 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 5, 0);
        chk_all("restart_slot0", 'h005, 0, 1, 0, 0);

        #2 reset = 1'b1;
        #1;
        chk_all("async_mid", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
